// File: rtl/p405s_icu_pkg.sv
// Shared ICU definitions: fetch sequencer state encoding, reset vector and line geometry.
package p405s_icu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_MISS = 2'b10,
    ST_FILL = 2'b11
  } fetch_seq_state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'hFFFF_FFFC;
  localparam logic [31:0] VA_WORD_MASK     = 32'hFFFF_FFFC;
  localparam int unsigned LINE_BYTES_DEF   = 32;
  localparam int unsigned LINE_OFF_W       = $clog2(LINE_BYTES_DEF);

endpackage

// File: rtl/p405s_icu_fetchvaseq_inc.sv
// Aligned fetch-address incrementer: (va & ~(FETCH_BYTES-1)) + FETCH_BYTES, wrapping mod 2^32.
module p405s_icu_fetchVaInc #(
  parameter int unsigned FETCH_BYTES = 8
) (
  input  logic [0:31] va_i,
  output logic [0:31] va_next_o
);

  localparam logic [31:0] STEP       = 32'(FETCH_BYTES);
  localparam logic [31:0] ALIGN_MASK = ~(STEP - 32'd1);

  always_comb begin
    va_next_o = (va_i & ALIGN_MASK) + STEP;
  end

endmodule

// File: rtl/p405s_icu_fetchvaseq.sv
// ICU fetch VA sequencer: chooses the next fetch address and load enable for the VA pipeline register.
module p405s_icu_fetchvaseq
  import p405s_icu_pkg::*;
#(
  parameter logic [0:31] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int unsigned FETCH_BYTES  = 8,
  parameter int unsigned LINE_BYTES   = LINE_BYTES_DEF
) (
  input  logic                                CB,
  input  logic                                resetCore_N,
  input  logic                                redirVld,
  input  logic [0:31]                         redirVa,
  input  logic                                fetchReq,
  input  logic                                icuHold,
  input  logic                                icuHit,
  input  logic                                icuMiss,
  input  logic                                missAck,
  input  logic                                fillDone,
  output logic [0:31]                         vaD,
  output logic                                vaE1,
  output logic                                missReq,
  output logic [0:31-$clog2(LINE_BYTES)]      missLineVa,
  output logic                                fetchVld
);

  localparam int unsigned OFF_W = $clog2(LINE_BYTES);

  fetch_seq_state_e       state_q, state_d;
  logic [0:31]            cur_va_q, cur_va_d;
  logic [0:31]            pend_va_q, pend_va_d;
  logic                   pend_redir_q, pend_redir_d;
  logic                   fill_done_q, fill_done_d;
  logic [0:31-OFF_W]      miss_line_q, miss_line_d;

  logic [0:31] redir_al;
  logic [0:31] seq_va;
  logic        load;
  logic [0:31] load_va;
  logic        fill_ready;
  logic        fill_redir;
  logic [0:31] fill_tgt;

  p405s_icu_fetchVaInc #(.FETCH_BYTES(FETCH_BYTES)) u_inc (
    .va_i      (cur_va_q),
    .va_next_o (seq_va)
  );

  always_comb begin
    redir_al   = redirVa & VA_WORD_MASK;
    fill_ready = fill_done_q | fillDone;
    fill_redir = pend_redir_q | redirVld;
    fill_tgt   = redirVld ? redir_al : pend_va_q;
  end

  always_comb begin
    state_d      = state_q;
    cur_va_d     = cur_va_q;
    pend_va_d    = pend_va_q;
    pend_redir_d = pend_redir_q;
    fill_done_d  = fill_done_q;
    miss_line_d  = miss_line_q;
    load         = 1'b0;
    load_va      = '0;

    case (state_q)
      ST_BOOT: begin
        load    = 1'b1;
        load_va = redirVld ? redir_al : RESET_VECTOR;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!icuHold) begin
          if (redirVld) begin
            load    = 1'b1;
            load_va = redir_al;
          end else if (icuMiss) begin
            state_d     = ST_MISS;
            miss_line_d = cur_va_q[0:31-OFF_W];
          end else if (icuHit && fetchReq) begin
            load    = 1'b1;
            load_va = seq_va;
          end
        end
      end
      ST_MISS: begin
        if (missAck) begin
          state_d = ST_FILL;
          if (redirVld) begin
            pend_redir_d = 1'b1;
            pend_va_d    = redir_al;
          end
        end else if (redirVld) begin
          // Request dropped under hold: park in FILL as an already-completed fill so the
          // redirect load happens once the hold releases.
          if (icuHold) begin
            state_d      = ST_FILL;
            pend_redir_d = 1'b1;
            pend_va_d    = redir_al;
            fill_done_d  = 1'b1;
          end else begin
            load    = 1'b1;
            load_va = redir_al;
            state_d = ST_RUN;
          end
        end
      end
      ST_FILL: begin
        if (redirVld) begin
          pend_redir_d = 1'b1;
          pend_va_d    = redir_al;
        end
        if (fillDone) fill_done_d = 1'b1;
        if (fill_ready && !icuHold) begin
          load         = 1'b1;
          load_va      = fill_redir ? fill_tgt : cur_va_q;
          pend_redir_d = 1'b0;
          fill_done_d  = 1'b0;
          state_d      = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (load) cur_va_d = load_va;
  end

  always_ff @(posedge CB or negedge resetCore_N) begin
    if (!resetCore_N) begin
      state_q      <= ST_BOOT;
      cur_va_q     <= RESET_VECTOR;
      pend_va_q    <= '0;
      pend_redir_q <= 1'b0;
      fill_done_q  <= 1'b0;
      miss_line_q  <= '0;
    end else begin
      state_q      <= state_d;
      cur_va_q     <= cur_va_d;
      pend_va_q    <= pend_va_d;
      pend_redir_q <= pend_redir_d;
      fill_done_q  <= fill_done_d;
      miss_line_q  <= miss_line_d;
    end
  end

  // Load enable is gated by reset so the BOOT-state default cannot leak out while reset is held.
  always_comb begin
    vaE1       = load & resetCore_N;
    vaD        = vaE1 ? load_va : '0;
    missReq    = (state_q == ST_MISS);
    fetchVld   = (state_q == ST_RUN);
    missLineVa = miss_line_q;
  end

endmodule

// File: doc/p405s_icu_fetchvaseq.md
Name: p405s_icu_fetchVaSeq

Overview:
- Fetch virtual-address sequencer in the ICU, one stage upstream of the 32-bit ICU VA pipeline register.
- Each cycle it decides whether that register loads, and with what address. It drives the register's D/E1 pair directly (vaD/vaE1).
- Sources of the next address: reset vector, sequential increment, branch/exception redirect, and replay after an I-cache miss line fill.
- Holds a private copy of the current fetch VA (curVa) so the increment never depends on the downstream register.

Parameters:
- RESET_VECTOR, 32'hFFFF_FFFC, first fetch address after reset.
- FETCH_BYTES, 8, bytes advanced per accepted fetch; must be a power of two, 4..16.
- LINE_BYTES, 32, I-cache line size; sets the missLineVa width.

Ports:
- CB  in  1  clock, rising edge.
- resetCore_N  in  1  asynchronous active-low reset.
- redirVld  in  1  redirect request (branch, exception, context sync).
- redirVa  in  [0:31]  redirect target; bits [30:31] ignored, forced to 0.
- fetchReq  in  1  IFB can accept the current fetch.
- icuHold  in  1  global ICU stall; freezes the sequencer.
- icuHit  in  1  lookup of curVa hit (sampled in RUN only).
- icuMiss  in  1  lookup of curVa missed (sampled in RUN only; mutually exclusive with icuHit).
- missAck  in  1  PLB interface accepted the line request.
- fillDone  in  1  one-cycle pulse: line fill complete.
- vaD  out  [0:31]  next VA, to the VA register D.
- vaE1  out  1  load enable, to the VA register E1.
- missReq  out  1  line-fill request, level, held until acked.
- missLineVa  out  [0:26]  line address of the miss (32-byte lines).
- fetchVld  out  1  curVa is a valid fetch address this cycle.

Behaviour:
- Async reset: state=BOOT, curVa=RESET_VECTOR, vaE1=0, vaD=0, missReq=0, missLineVa=0, fetchVld=0, pendRedir=0.
- vaD and vaE1 are combinational from state and inputs. The downstream register therefore updates on the same edge as curVa. Zero added latency.
- Sequential next address:
  - seqVa = (curVa & ~(FETCH_BYTES-1)) + FETCH_BYTES, modulo 2^32.
  - 0xFFFF_FFF8 wraps to 0x0000_0000.
  - The reset-vector fetch 0xFFFF_FFFC advances to 0x0000_0000.
- BOOT: first cycle after reset release.
  - vaE1=1, vaD=RESET_VECTOR → RUN.
  - If redirVld is high in that cycle, redirVa wins.
- RUN: fetchVld=1. Priority order:
  1. icuHold: vaE1=0, no state change, all inputs ignored except async reset.
  2. redirVld: vaE1=1, vaD=redirVa, curVa=redirVa, stay RUN. A simultaneous icuMiss is discarded.
  3. icuMiss: → MISS, missReq=1, missLineVa=curVa[0:26], vaE1=0.
  4. icuHit & fetchReq: vaE1=1, vaD=seqVa, curVa=seqVa.
  5. Otherwise: vaE1=0.
- MISS: missReq held at 1, fetchVld=0.
  - missAck → missReq=0, → FILL.
  - redirVld before ack: drop the request (missReq=0 next cycle), load redirVa (vaE1=1), → RUN.
  - If missAck and redirVld arrive in the same cycle, the ack wins: → FILL, pendRedir=1, redirVa latched.
- FILL: waiting for fillDone, fetchVld=0, vaE1=0.
  - redirVld: latch redirVa into pendVa, pendRedir=1. The last redirect wins.
  - fillDone: if pendRedir, vaD=pendVa; else vaD=curVa (replay). vaE1=1, pendRedir=0, → RUN.
- icuHold in MISS/FILL freezes only the vaE1 load. missReq, missAck and fillDone are still honoured; the load is deferred until the hold drops, with the result kept in pendVa.
- Reset mid-fill: immediate return to BOOT state values. The outstanding fill is the PLB side's responsibility.
- No X on outputs at any time after reset.

Decomposition:
- Shared package p405s_icu_pkg:
  - state encoding: BOOT=2'b00, RUN=2'b01, MISS=2'b10, FILL=2'b11;
  - RESET_VECTOR default;
  - line-offset width constant.
- One sub-module: p405s_icu_fetchVaInc, the combinational aligned +FETCH_BYTES incrementer with wrap. It is reused by the IFB prefetch logic.

Test Plan:
- Reset release, fetchReq=1, icuHit=1 → vaE1 cycle 1 vaD=0xFFFF_FFFC; then 0x0000_0000, 0x0000_0008, 0x0000_0010 on consecutive cycles.
- Redirect to 0x0000_1236 while running → vaD=0x0000_1234 same cycle; next seq 0x0000_1238; a simultaneous icuMiss yields no missReq.
- icuMiss at curVa=0x0000_2048 → missReq=1, missLineVa=0x0000_2040>>5; hold 3 cycles, missAck → missReq=0; fillDone → vaE1=1, vaD=0x0000_2048.
- Miss then redirVld=0x0000_8000 during FILL, then a second redirect 0x0000_9000 → after fillDone vaD=0x0000_9000, single vaE1 pulse.
- curVa=0xFFFF_FFF8 with hit → vaD=0x0000_0000; icuHold=1 for 2 cycles → vaE1=0, curVa unchanged.
- resetCore_N low mid-FILL → asynchronously missReq=0, vaE1=0, fetchVld=0; after release, BOOT reload of 0xFFFF_FFFC.
